// File: rtl/raster_tx_if.sv
// Load-port and pixel-stream bundle for raster_tx. The transmitter takes the master side;
// the loader/consumer (image path or bench) takes the slave side.
interface raster_tx_if #(
   parameter int WIDTH_P = 8
);
   logic               wr_valid_i;
   logic               wr_ready_o;
   logic [WIDTH_P-1:0] wr_data_i;
   logic               valid_o;
   logic               ready_i;
   logic [WIDTH_P-1:0] data_o;
   logic               sof_o;
   logic               eol_o;
   logic               eof_o;

   modport master (
      input  wr_valid_i, wr_data_i, ready_i,
      output wr_ready_o, valid_o, data_o, sof_o, eol_o, eof_o
   );

   modport slave (
      output wr_valid_i, wr_data_i, ready_i,
      input  wr_ready_o, valid_o, data_o, sof_o, eol_o, eof_o
   );
endinterface

// File: rtl/raster_tx.sv
// raster_tx: buffers one frame from the load port and replays it in raster order with
// sof/eol/eof markers. Define RASTER_TX_PAD_EN to stream a one-pixel zero border around it.
module raster_tx #(
   parameter int WIDTH_P  = 8,
   parameter int DEPTH_P  = 16,
   parameter int HEIGHT_P = 16
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   output logic        busy_o,
   raster_tx_if.master bus
);

`ifdef RASTER_TX_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif

   localparam int NPIX  = DEPTH_P * HEIGHT_P;
   localparam int OUT_W = DEPTH_P + 2 * PAD;
   localparam int OUT_H = HEIGHT_P + 2 * PAD;
   localparam int AW    = (NPIX  > 1) ? $clog2(NPIX)  : 1;
   localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
   localparam int RW    = (OUT_H > 1) ? $clog2(OUT_H) : 1;

   localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
   localparam logic [CW-1:0] LAST_COL  = CW'(OUT_W - 1);
   localparam logic [RW-1:0] LAST_ROW  = RW'(OUT_H - 1);

   typedef enum logic [1:0] {
      ST_LOAD,
      ST_READY,
      ST_STREAM
   } state_e;

   state_e             state_q, state_d;
   logic [WIDTH_P-1:0] mem [NPIX];
   logic [WIDTH_P-1:0] rd_data_q;
   logic [AW-1:0]      wptr_q, wptr_d;
   logic [AW-1:0]      raddr_q, raddr_d;
   logic [CW-1:0]      rd_col_q, rd_col_d;
   logic [RW-1:0]      rd_row_q, rd_row_d;
   logic               rd_done_q, rd_done_d;
   logic               s1_valid_q, s1_valid_d;
   logic               s1_zero_q, s1_zero_d;
   logic               valid_q, valid_d;
   logic [WIDTH_P-1:0] data_q, data_d;
   logic [CW-1:0]      col_q, col_d;
   logic [RW-1:0]      row_q, row_d;

   logic wr_fire, out_take, out_fire, s1_move, issue, interior;
   logic sof, eol, eof;

   // Read side is a two-stage pipe: s1 holds the RAM word, the output register holds the
   // presented pixel. A read is only issued when s1 is guaranteed free next cycle.
   assign bus.wr_ready_o = (state_q == ST_LOAD) & ~rst_i;
   assign wr_fire  = bus.wr_valid_i & bus.wr_ready_o;
   assign out_take = ~valid_q | bus.ready_i;
   assign out_fire = valid_q & bus.ready_i;
   assign s1_move  = s1_valid_q & out_take;
   assign issue    = ((state_q == ST_READY) & start_i) |
                     ((state_q == ST_STREAM) & ~rd_done_q & (~s1_valid_q | s1_move));

`ifdef RASTER_TX_PAD_EN
   assign interior = (rd_col_q != '0) && (rd_col_q != LAST_COL) &&
                     (rd_row_q != '0) && (rd_row_q != LAST_ROW);
`else
   assign interior = 1'b1;
`endif

   assign sof = (row_q == '0) && (col_q == '0);
   assign eol = (col_q == LAST_COL);
   assign eof = eol && (row_q == LAST_ROW);

   assign busy_o      = (state_q == ST_STREAM);
   assign bus.valid_o = valid_q;
   assign bus.data_o  = data_q;
   assign bus.sof_o   = valid_q & sof;
   assign bus.eol_o   = valid_q & eol;
   assign bus.eof_o   = valid_q & eof;

   always_comb begin
      // NOTE: every _d gets its hold value first so no path through this block infers a latch.
      state_d    = state_q;
      wptr_d     = wptr_q;
      raddr_d    = raddr_q;
      rd_col_d   = rd_col_q;
      rd_row_d   = rd_row_q;
      rd_done_d  = rd_done_q;
      s1_valid_d = s1_valid_q;
      s1_zero_d  = s1_zero_q;
      valid_d    = valid_q;
      data_d     = data_q;
      col_d      = col_q;
      row_d      = row_q;

      case (state_q)
         ST_LOAD: begin
            if (wr_fire) begin
               wptr_d = (wptr_q == LAST_ADDR) ? '0 : wptr_q + 1'b1;
               if (wptr_q == LAST_ADDR) state_d = ST_READY;
            end
         end
         ST_READY: begin
            if (start_i) begin
               state_d   = ST_STREAM;
               col_d     = '0;
               row_d     = '0;
               rd_done_d = 1'b0;
            end
         end
         ST_STREAM: begin
            if (out_fire && eof) begin
               state_d = ST_LOAD;
               wptr_d  = '0;
            end
         end
         default: state_d = ST_LOAD;
      endcase

      if (issue) begin
         rd_col_d  = (rd_col_q == LAST_COL) ? '0 : rd_col_q + 1'b1;
         s1_zero_d = ~interior;
         if (rd_col_q == LAST_COL) begin
            rd_row_d = (rd_row_q == LAST_ROW) ? '0 : rd_row_q + 1'b1;
            if (rd_row_q == LAST_ROW) rd_done_d = 1'b1;
         end
         if (interior) raddr_d = (raddr_q == LAST_ADDR) ? '0 : raddr_q + 1'b1;
      end
      s1_valid_d = issue | (s1_valid_q & ~s1_move);

      if (out_take) begin
         valid_d = s1_valid_q;
         if (s1_valid_q) data_d = s1_zero_q ? '0 : rd_data_q;
      end

      if (out_fire) begin
         col_d = eol ? '0 : col_q + 1'b1;
         if (eol) row_d = eof ? '0 : row_q + 1'b1;
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_LOAD;
         wptr_q     <= '0;
         raddr_q    <= '0;
         rd_col_q   <= '0;
         rd_row_q   <= '0;
         rd_done_q  <= 1'b0;
         s1_valid_q <= 1'b0;
         s1_zero_q  <= 1'b0;
         valid_q    <= 1'b0;
         data_q     <= '0;
         col_q      <= '0;
         row_q      <= '0;
      end else begin
         state_q    <= state_d;
         wptr_q     <= wptr_d;
         raddr_q    <= raddr_d;
         rd_col_q   <= rd_col_d;
         rd_row_q   <= rd_row_d;
         rd_done_q  <= rd_done_d;
         s1_valid_q <= s1_valid_d;
         s1_zero_q  <= s1_zero_d;
         valid_q    <= valid_d;
         data_q     <= data_d;
         col_q      <= col_d;
         row_q      <= row_d;
      end
   end

   // NOTE: the frame RAM and its read register carry no reset so they map onto block RAM;
   // s1_valid_q decides whether rd_data_q means anything.
   always_ff @(posedge clk_i) begin
      if (wr_fire) mem[wptr_q] <= bus.wr_data_i;
      if (issue && interior) rd_data_q <= mem[raddr_q];
   end

endmodule

// File: doc/raster_tx.md
# raster_tx

Raster-scan pixel transmitter feeding the sliding-window filter stage. It buffers one full frame written through a valid/ready load port. On `start_i` it replays the frame pixel by pixel in row-major order on a valid/ready stream, one pixel per handshake, with start-of-frame, end-of-line and end-of-frame markers. It is the producer end of the pixel stream that the 3x3 window/line-buffer logic consumes, and it drives that logic in testbenches and in the image path.

## Interface
- `WIDTH_P`, 8, pixel width in bits
- `DEPTH_P`, 16, pixels per row (line length, matches downstream line-buffer depth)
- `HEIGHT_P`, 16, rows per frame
- `clk_i`  in  1  clock, all logic on rising edge
- `rst_i`  in  1  synchronous, active-high reset
- `wr_valid_i`  in  1  load-port pixel valid
- `wr_ready_o`  out  1  load-port ready; high only in LOAD
- `wr_data_i`  in  WIDTH_P  load-port pixel, raster order
- `start_i`  in  1  begin streaming; sampled only in READY
- `busy_o`  out  1  high in STREAM
- `valid_o`  out  1  output pixel valid
- `ready_i`  in  1  downstream ready
- `data_o`  out  WIDTH_P  output pixel
- `sof_o`  out  1  first pixel of frame (qualified by `valid_o`)
- `eol_o`  out  1  last pixel of a row
- `eof_o`  out  1  last pixel of frame

## Operation
- Frame RAM: `DEPTH_P*HEIGHT_P` x `WIDTH_P`, synchronous read, one-cycle read latency.
- FSM states: LOAD, READY, STREAM.
  - LOAD: `wr_ready_o`=1. Each `wr_valid_i & wr_ready_o` writes to address `wptr`, then `wptr++`. The write at `wptr = DEPTH_P*HEIGHT_P-1` moves the FSM to READY next cycle.
  - READY: `wr_ready_o`=0. `start_i`=1 moves the FSM to STREAM and clears the column and row counters.
  - STREAM: pixels are emitted in row-major order. On the handshake (`valid_o & ready_i`) of the `eof_o` pixel, the FSM goes to LOAD with `wptr`=0. RAM contents are kept but will be overwritten.
- Counters: `col` counts 0..`DEPTH_P-1` and `row` counts 0..`HEIGHT_P-1`. `col` wraps to 0 and `row` increments on the handshake of an `eol_o` pixel.
- Markers:
  - `sof_o`=1 only for (row 0, col 0).
  - `eol_o`=1 when col = `DEPTH_P-1`.
  - `eof_o`=1 when `eol_o` is high and row = `HEIGHT_P-1`.
- Handshake:
  - Once `valid_o` is raised, it stays high until accepted.
  - While `valid_o & !ready_i`, `data_o` and all markers hold stable.
  - `valid_o` never depends combinationally on `ready_i`.
- Internal prefetch or skid registers make throughput one pixel per cycle while `ready_i` is held high. No bubbles are allowed between the first and last pixel.
- `start_i` in LOAD or STREAM is ignored. `wr_valid_i` outside LOAD is ignored and causes no write.
- Reset values: `valid_o`=0, `busy_o`=0, `wr_ready_o`=0 during reset, `data_o`=0, all markers 0. After reset the state is LOAD with `wptr`=0, so `wr_ready_o`=1 on the first cycle after reset deasserts.
- Reset mid-STREAM: `valid_o` drops the cycle after `rst_i` is sampled, and any pending pixel is discarded.

## Timing
- Load: one pixel per cycle. READY is entered one cycle after the last write.
- `start_i` sampled high at edge N: `busy_o`=1 from N+1, and the first `valid_o` (with `sof_o`) is high at N+2 (RAM read plus output register).
- With `ready_i` held high, the frame completes in `DEPTH_P*HEIGHT_P` consecutive cycles. `busy_o` falls and `wr_ready_o` rises the cycle after the `eof_o` handshake.
- Backpressure: if `ready_i` is low for k cycles, completion is delayed by exactly k cycles.

## Configuration
- `RASTER_TX_PAD_EN`: when defined, the streamed frame is `(DEPTH_P+2)` x `(HEIGHT_P+2)` with a one-pixel zero border, so downstream 3x3 windows cover edge pixels.
  - Border pixels are emitted as `data_o`=0 and do not read the RAM.
  - Interior pixel (r+1, c+1) equals stored pixel (r, c).
  - Counter limits and markers use the padded dimensions, and frame time is `(DEPTH_P+2)*(HEIGHT_P+2)` cycles.
- When the macro is undefined, there is no padding and the behaviour is exactly as described above.

## Test plan
The scenarios below use `DEPTH_P`=4 and `HEIGHT_P`=3.

- Reset, then write 12 pixels 1..12 with `wr_valid_i` held high -> `wr_ready_o` falls after the 12th write; `start_i` pulse -> `valid_o` high 2 cycles later with `data_o`=1 and `sof_o`=1.
- `ready_i` held high -> sequence 1..12 over 12 consecutive cycles, `eol_o` on 4, 8, 12, `eof_o` only on 12, then `busy_o`=0 and `wr_ready_o`=1.
- `ready_i` toggled 1,0,0,1,... -> no pixel lost or duplicated; `data_o` and markers stable while stalled; total completion time = 12 + number of stall cycles.
- `start_i` during LOAD, and `wr_valid_i` with `wr_data_i`=0xFF during STREAM -> no start and no write; streamed data is still 1..12.
- `rst_i` asserted after the 5th accepted pixel -> `valid_o`=0 next cycle, `wr_ready_o`=1 after release, and a fresh load of 12 pixels streams correctly.
- With `RASTER_TX_PAD_EN`: 30 pixels are streamed; row 0 and row 4 are all zero; row 1 is 0,1,2,3,4,0; `eol_o` every 6th pixel; `eof_o` on the 30th.
